// File: rtl/a_send_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | a_send_pkg : shared types and defaults for the A-side send arbiter |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package a_send_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_DW     = 8;
  localparam int DEF_TO_CYC = 1024;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/a_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | a_rr_pick : combinational rotate-priority picker                  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module a_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   pick_idx,
  output logic            any
);

  // One spare bit so ptr + offset can exceed NREQ-1 before the wrap.
  logic [PW:0] w_sum;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    w_sum    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(NREQ)) begin
        w_sum = w_sum - (PW+1)'(NREQ);
      end
      if (!any && req[w_sum[PW-1:0]]) begin
        any      = 1'b1;
        pick_idx = w_sum[PW-1:0];
      end
    end
    pick[pick_idx] = any;
  end

endmodule
`default_nettype wire

// File: rtl/a_send_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | a_send_arb : round-robin arbiter for the A-domain send channel    |
// | Build option: A_SEND_ARB_TIMEOUT_EN adds a sticky ack timeout.    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module a_send_arb
  import a_send_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int DW     = DEF_DW,
  parameter int TO_CYC = DEF_TO_CYC
) (
  input  logic               aclk,
  input  logic               arst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  input  logic               aready,
  output logic               asend,
  output logic [DW-1:0]      adata,
  input  logic               aack,
  output logic               abusy,
  output logic               atimeout
);

  localparam int PW = ptr_w(NREQ);

  arb_state_t      r_state;
  arb_state_t      w_next;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [DW-1:0]   r_adata;
  logic [NREQ-1:0] r_done;
  logic [NREQ-1:0] w_pick;
  logic [PW-1:0]   w_pick_idx;
  logic            w_any;
  logic [DW-1:0]   w_pick_data;
  logic [NREQ-1:0] w_owner_oh;
  logic            w_arb;

  a_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req      (req),
    .ptr      (r_ptr),
    .pick     (w_pick),
    .pick_idx (w_pick_idx),
    .any      (w_any)
  );

  always_comb begin
    w_pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) begin
        w_pick_data = req_data[i*DW +: DW];
      end
    end
  end

  assign w_arb = (r_state == IDLE) && aready && w_any;

  always_ff @(posedge aclk) begin
    if (arst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_arb) w_next = SEND;
      SEND:    w_next = WAIT;
      WAIT:    if (aack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
    asend = (r_state == SEND);
    abusy = (r_state == SEND) || (r_state == WAIT);
    gnt   = (r_state == SEND) ? w_owner_oh : '0;
  end

  // adata is only reloaded at arbitration, so it stays put from asend through done.
  always_ff @(posedge aclk) begin
    if (arst) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_adata <= '0;
      r_done  <= '0;
    end else begin
      if (w_arb) begin
        r_adata <= w_pick_data;
        r_owner <= w_pick_idx;
        r_ptr   <= (w_pick_idx == PW'(NREQ-1)) ? '0 : w_pick_idx + PW'(1);
      end
      r_done <= ((r_state == WAIT) && aack) ? w_owner_oh : '0;
    end
  end

  assign adata = r_adata;
  assign done  = r_done;

`ifdef A_SEND_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);

  logic [CW-1:0] r_to_cnt;
  logic          r_timeout;

  // Flag rises on the edge the count reaches TO_CYC; the FSM keeps waiting.
  always_ff @(posedge aclk) begin
    if (arst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == SEND) begin
      r_to_cnt <= '0;
    end else if (r_state == WAIT) begin
      if (r_to_cnt != CW'(TO_CYC)) begin
        r_to_cnt <= r_to_cnt + CW'(1);
      end
      if (r_to_cnt == CW'(TO_CYC - 1)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign atimeout = r_timeout;
`else
  logic [31:0] unused_to_cyc;
  assign unused_to_cyc = 32'(TO_CYC);
  assign atimeout      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_a_send_arb.sv
`default_nettype none
// tb_a_send_arb : scoreboard bench for the A-side round-robin send arbiter.
module tb_a_send_arb;

  localparam int NREQ   = 4;
  localparam int DW     = 8;
  localparam int TO_CYC = 16;
`ifdef A_SEND_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic               aclk = 1'b0;
  logic               arst;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               aready;
  logic               asend;
  logic [DW-1:0]      adata;
  logic               aack;
  logic               abusy;
  logic               atimeout;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 0;

  typedef struct {
    logic [NREQ-1:0] oh;
    logic [DW-1:0]   data;
  } exp_t;
  exp_t sb[$];

  always #5 aclk = ~aclk;

  a_send_arb #(
    .NREQ   (NREQ),
    .DW     (DW),
    .TO_CYC (TO_CYC)
  ) dut (
    .aclk     (aclk),
    .arst     (arst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .aready   (aready),
    .asend    (asend),
    .adata    (adata),
    .aack     (aack),
    .abusy    (abusy),
    .atimeout (atimeout)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge aclk);
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    arst   = 1'b1;
    req    = '0;
    aack   = 1'b0;
    aready = 1'b0;
    tick();
    tick();
    arst  = 1'b0;
    m_ptr = 0;
    sb.delete();
  endtask

  // Caller leaves the DUT idle with req/req_data/aready set; arbitration is on the next edge.
  task automatic xfer(input string nm, input int exp_w, input int ack_dly, input bit keep);
    exp_t e;
    int   k;
    e.oh        = '0;
    e.oh[exp_w] = 1'b1;
    e.data      = req_data[exp_w*DW +: DW];
    sb.push_back(e);
    m_ptr = (exp_w + 1) % NREQ;
    k = 0;
    tick();
    while (asend !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    e = sb.pop_front();
    n_cmp++;
    if (asend !== 1'b1 || k != 0) begin
      n_err++;
      $display("FAIL %s latency: asend=%b after %0d extra cycles, required asend=1 after 0", nm, asend, k);
    end
    n_cmp++;
    if (gnt !== e.oh || adata !== e.data || abusy !== 1'b1) begin
      n_err++;
      $display("FAIL %s grant: gnt=%b adata=%h abusy=%b, required gnt=%b adata=%h abusy=1",
               nm, gnt, adata, abusy, e.oh, e.data);
    end
    if (!keep) req[exp_w] = 1'b0;
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      n_cmp++;
      if (asend !== 1'b0 || gnt !== '0 || done !== '0 || abusy !== 1'b1 || adata !== e.data) begin
        n_err++;
        $display("FAIL %s hold c%0d: asend=%b gnt=%b done=%b abusy=%b adata=%h, required 0/0/0/1/%h",
                 nm, i + 1, asend, gnt, done, abusy, adata, e.data);
      end
    end
    aack = 1'b1;
    tick();
    aack = 1'b0;
    n_cmp++;
    if (done !== e.oh || abusy !== 1'b0 || asend !== 1'b0 || adata !== e.data) begin
      n_err++;
      $display("FAIL %s done: done=%b abusy=%b asend=%b adata=%h, required done=%b abusy=0 asend=0 adata=%h",
               nm, done, abusy, asend, adata, e.oh, e.data);
    end
  endtask

  task automatic test_reset();
    req_data = '0;
    do_reset();
    n_cmp++;
    if (asend !== 1'b0 || gnt !== '0 || done !== '0 || abusy !== 1'b0 || adata !== '0 || atimeout !== 1'b0) begin
      n_err++;
      $display("FAIL reset: asend=%b gnt=%b done=%b abusy=%b adata=%h atimeout=%b, required all 0",
               asend, gnt, done, abusy, adata, atimeout);
    end
  endtask

  task automatic test_single();
    req_data       = '0;
    req_data[23:16] = 8'h5A;
    req            = 4'b0100;
    aready         = 1'b1;
    xfer("single", 2, 5, 1'b0);
  endtask

  task automatic test_fairness();
    int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 8'(8'h10 + i * 8'h11);
    req    = 4'b1111;
    aready = 1'b1;
    for (int i = 0; i < 8; i++) xfer($sformatf("rr%0d", i), order[i], 2, 1'b1);
  endtask

  task automatic test_wrap_skip();
    req = 4'b0100;
    xfer("wrap_pre", model_pick(req, m_ptr), 1, 1'b0);
    req = 4'b0011;
    xfer("wrap0", 0, 1, 1'b0);
    xfer("wrap1", 1, 1, 1'b0);
  endtask

  task automatic test_busy();
    aready = 1'b0;
    req    = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (asend !== 1'b0 || gnt !== '0 || abusy !== 1'b0) begin
        n_err++;
        $display("FAIL busy c%0d: asend=%b gnt=%b abusy=%b, required 0/0/0", i, asend, gnt, abusy);
      end
    end
    aready = 1'b1;
    xfer("busy", model_pick(req, m_ptr), 3, 1'b0);
  endtask

  task automatic test_spurious_and_reset();
    req  = '0;
    aack = 1'b1;
    tick();
    aack = 1'b0;
    n_cmp++;
    if (done !== '0 || abusy !== 1'b0) begin
      n_err++;
      $display("FAIL spurious: done=%b abusy=%b, required done=0 abusy=0", done, abusy);
    end
    tick();
    n_cmp++;
    if (done !== '0) begin
      n_err++;
      $display("FAIL spurious2: done=%b, required 0", done);
    end
    req_data[15:8] = 8'hA7;
    req            = 4'b0010;
    aready         = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (abusy !== 1'b1 || asend !== 1'b0 || adata !== 8'hA7) begin
      n_err++;
      $display("FAIL midrst_wait: abusy=%b asend=%b adata=%h, required abusy=1 asend=0 adata=a7", abusy, asend, adata);
    end
    arst = 1'b1;
    req  = '0;
    tick();
    arst = 1'b0;
    m_ptr = 0;
    n_cmp++;
    if (asend !== 1'b0 || gnt !== '0 || done !== '0 || abusy !== 1'b0 || adata !== '0) begin
      n_err++;
      $display("FAIL midrst_out: asend=%b gnt=%b done=%b abusy=%b adata=%h, required all 0",
               asend, gnt, done, abusy, adata);
    end
    aack = 1'b1;
    tick();
    aack = 1'b0;
    n_cmp++;
    if (done !== '0 || abusy !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_ack: done=%b abusy=%b, required done=0 abusy=0", done, abusy);
    end
  endtask

  task automatic test_timeout();
    logic exp;
    do_reset();
    req_data       = '0;
    req_data[7:0]  = 8'hC3;
    req            = 4'b0001;
    aready         = 1'b1;
    tick();
    n_cmp++;
    if (asend !== 1'b1 || gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL tmo_send: asend=%b gnt=%b, required asend=1 gnt=0001", asend, gnt);
    end
    req = '0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i >= 16) begin
        exp = TMO && (i == 17);
        n_cmp++;
        if (atimeout !== exp) begin
          n_err++;
          $display("FAIL tmo_wait%0d: atimeout=%b, required %b", i, atimeout, exp);
        end
      end
    end
    n_cmp++;
    if (abusy !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_busy: abusy=%b, required 1", abusy);
    end
    aack = 1'b1;
    tick();
    aack = 1'b0;
    n_cmp++;
    if (done !== 4'b0001 || atimeout !== TMO || adata !== 8'hC3) begin
      n_err++;
      $display("FAIL tmo_ack: done=%b atimeout=%b adata=%h, required done=0001 atimeout=%b adata=c3",
               done, atimeout, adata, TMO);
    end
    tick();
    tick();
    n_cmp++;
    if (atimeout !== TMO) begin
      n_err++;
      $display("FAIL tmo_sticky: atimeout=%b, required %b", atimeout, TMO);
    end
    do_reset();
    n_cmp++;
    if (atimeout !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_clear: atimeout=%b, required 0", atimeout);
    end
  endtask

  initial begin
    arst     = 1'b1;
    req      = '0;
    req_data = '0;
    aready   = 1'b0;
    aack     = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_wrap_skip();
    test_busy();
    test_spurious_and_reset();
    test_timeout();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
